// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Hazard control for a classic 5-stage in-order pipeline.
//             Detects load-use hazards and stalls for LOAD_LAT cycles,
//             flushes IF-ID on taken branches, freezes the pipeline while
//             data memory is busy, and selects ALU operand forwarding.
//  Ports    : clk, reset_n            - clock, async active-low reset
//             ifid_* / idex_*         - source/destination info of ID and EX
//             exmem_* / memwb_*       - writeback info of MEM and WB
//             branch_taken, mem_wait  - control events
//             pc_write, ifid_write, idex_mux_out, ifid_flush, pipe_freeze
//                                     - pipeline register controls
//             forward_a, forward_b    - ALU operand select (10 EX-MEM, 01 MEM-WB)
//             stall_cycles            - saturating load-use stall counter
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] ifid_rs1,
  input  logic [REG_AW-1:0] ifid_rs2,
  input  logic              ifid_use_rs1,
  input  logic              ifid_use_rs2,
  input  logic [REG_AW-1:0] idex_rs1,
  input  logic [REG_AW-1:0] idex_rs2,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_regwrite,
  input  logic              branch_taken,
  input  logic              mem_wait,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_mux_out,
  output logic              ifid_flush,
  output logic              pipe_freeze,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [0:0] {
    S_RUN    = 1'b0,
    S_LSTALL = 1'b1
  } state_t;

  // Cycles still owed after the first stall cycle spent in RUN.
  localparam logic [3:0] C_LAT_M1 = 4'(LOAD_LAT - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_inc;
  logic             lu_hazard;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign lu_hazard = idex_memread && (idex_rd != '0) &&
                     ((ifid_use_rs1 && (idex_rd == ifid_rs1)) ||
                      (ifid_use_rs2 && (idex_rd == ifid_rs2)));

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs))
      return 2'b10;
    else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Outputs are gated by reset_n so they take reset values immediately,
  // without waiting for the registered state to be cleared by an edge.
  assign forward_a    = reset_n ? fwd_sel(idex_rs1) : 2'b00;
  assign forward_b    = reset_n ? fwd_sel(idex_rs2) : 2'b00;
  assign stall_cycles = stall_cnt_q;

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_mux_out = 1'b1;
    ifid_flush   = 1'b0;
    pipe_freeze  = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_inc    = 1'b0;

    if (!reset_n) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_mux_out = 1'b0;
      ifid_flush   = 1'b1;
      state_d      = S_RUN;
      cnt_d        = 4'd0;
    end else if (mem_wait) begin
      // Whole pipeline holds; stall progress is paused, not consumed.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
    end else if (branch_taken) begin
      // The stalled instruction is on the wrong path, so abort any stall.
      ifid_flush   = 1'b1;
      idex_mux_out = 1'b0;
      state_d      = S_RUN;
      cnt_d        = 4'd0;
    end else if (state_q == S_RUN && lu_hazard) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_mux_out = 1'b0;
      stall_inc    = 1'b1;
      if (LOAD_LAT > 1) begin
        state_d = S_LSTALL;
        cnt_d   = C_LAT_M1;
      end
    end else if (state_q == S_LSTALL) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_mux_out = 1'b0;
      stall_inc    = 1'b1;
      if (cnt_q == 4'd1) begin
        state_d = S_RUN;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RUN;
      cnt_q       <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Purpose  : Self-checking bench: two instances (LOAD_LAT=1 / LOAD_LAT=3,
//             the latter with a 4-bit stall counter to reach saturation),
//             directed scenarios followed by randomized traffic, compared
//             against a behavioural model tracking "stall cycles remaining".
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic ifid_use_rs1, ifid_use_rs2, idex_memread, exmem_regwrite, memwb_regwrite;
  logic branch_taken, mem_wait;

  logic u1_pc, u1_ifw, u1_mux, u1_fl, u1_fz;
  logic [1:0] u1_fa, u1_fb;
  logic [15:0] u1_sc;
  logic u3_pc, u3_ifw, u3_mux, u3_fl, u3_fz;
  logic [1:0] u3_fa, u3_fb;
  logic [3:0] u3_sc;

  pipeline_hazard_ctrl #(.REG_AW(AW), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
    .clk(clk), .reset_n(reset_n),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
    .idex_rd(idex_rd), .idex_memread(idex_memread),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .branch_taken(branch_taken), .mem_wait(mem_wait),
    .pc_write(u1_pc), .ifid_write(u1_ifw), .idex_mux_out(u1_mux),
    .ifid_flush(u1_fl), .pipe_freeze(u1_fz),
    .forward_a(u1_fa), .forward_b(u1_fb), .stall_cycles(u1_sc)
  );

  pipeline_hazard_ctrl #(.REG_AW(AW), .LOAD_LAT(3), .CNT_W(4)) u_lat3 (
    .clk(clk), .reset_n(reset_n),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
    .idex_rd(idex_rd), .idex_memread(idex_memread),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .branch_taken(branch_taken), .mem_wait(mem_wait),
    .pc_write(u3_pc), .ifid_write(u3_ifw), .idex_mux_out(u3_mux),
    .ifid_flush(u3_fl), .pipe_freeze(u3_fz),
    .forward_a(u3_fa), .forward_b(u3_fb), .stall_cycles(u3_sc)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: stall cycles still owed, and accumulated stall count.
  int rem1 = 0, rem3 = 0;
  int sc1 = 0, sc3 = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit load_use();
    return idex_memread && (idex_rd != 0) &&
           ((ifid_use_rs1 && idex_rd == ifid_rs1) || (ifid_use_rs2 && idex_rd == ifid_rs2));
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [AW-1:0] rs);
    if (!reset_n) return 2'b00;
    if (exmem_regwrite && exmem_rd != 0 && exmem_rd == rs) return 2'b10;
    if (memwb_regwrite && memwb_rd != 0 && memwb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  // ctl = {pc_write, ifid_write, idex_mux_out, ifid_flush, pipe_freeze}
  task automatic model_ctl(input int lat, input int rem, output logic [4:0] ctl,
                           output int rem_n, output bit inc);
    inc   = 1'b0;
    rem_n = rem;
    if (!reset_n) begin
      ctl = 5'b00010; rem_n = 0;
    end else if (mem_wait) begin
      ctl = 5'b00101;
    end else if (branch_taken) begin
      ctl = 5'b11010; rem_n = 0;
    end else if (rem > 0) begin
      ctl = 5'b00000; rem_n = rem - 1; inc = 1'b1;
    end else if (load_use()) begin
      ctl = 5'b00000; rem_n = lat - 1; inc = 1'b1;
    end else begin
      ctl = 5'b11100;
    end
  endtask

  // Called just after a negedge with inputs already applied: checks
  // outputs mid-cycle, then advances the model across the next posedge.
  task automatic cycle();
    logic [4:0] c1, c3;
    int rn1, rn3;
    bit i1, i3;
    #1;
    model_ctl(1, rem1, c1, rn1, i1);
    model_ctl(3, rem3, c3, rn3, i3);
    check_eq("lat1.ctl", {27'd0, u1_pc, u1_ifw, u1_mux, u1_fl, u1_fz}, {27'd0, c1});
    check_eq("lat1.fwd_a", {30'd0, u1_fa}, {30'd0, exp_fwd(idex_rs1)});
    check_eq("lat1.fwd_b", {30'd0, u1_fb}, {30'd0, exp_fwd(idex_rs2)});
    check_eq("lat1.stall_cycles", {16'd0, u1_sc}, reset_n ? sc1 : 0);
    check_eq("lat3.ctl", {27'd0, u3_pc, u3_ifw, u3_mux, u3_fl, u3_fz}, {27'd0, c3});
    check_eq("lat3.fwd_a", {30'd0, u3_fa}, {30'd0, exp_fwd(idex_rs1)});
    check_eq("lat3.fwd_b", {30'd0, u3_fb}, {30'd0, exp_fwd(idex_rs2)});
    check_eq("lat3.stall_cycles", {28'd0, u3_sc}, reset_n ? sc3 : 0);
    @(posedge clk);
    if (!reset_n) begin
      rem1 = 0; rem3 = 0; sc1 = 0; sc3 = 0;
    end else begin
      rem1 = rn1; rem3 = rn3;
      if (i1 && sc1 < 65535) sc1++;
      if (i3 && sc3 < 15) sc3++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    ifid_rs1 = 0; ifid_rs2 = 0; ifid_use_rs1 = 0; ifid_use_rs2 = 0;
    idex_rs1 = 0; idex_rs2 = 0; idex_rd = 0; idex_memread = 0;
    exmem_rd = 0; exmem_regwrite = 0; memwb_rd = 0; memwb_regwrite = 0;
    branch_taken = 0; mem_wait = 0;
  endtask

  task automatic set_load_use();
    idex_memread = 1; idex_rd = 5; ifid_rs1 = 5; ifid_use_rs1 = 1;
  endtask

  initial begin
    idle();
    @(negedge clk);
    // Reset state
    repeat (2) cycle();
    reset_n = 1'b1;

    // Single load-use event: lat1 stalls 1 cycle, lat3 stalls 3 cycles
    set_load_use(); cycle();
    idle(); repeat (4) cycle();
    check_eq("lat1.one_event", {16'd0, u1_sc}, 32'd1);
    check_eq("lat3.one_event", {28'd0, u3_sc}, 32'd3);

    // mem_wait for 2 cycles while lat3 is in LSTALL cnt=2
    set_load_use(); cycle();
    idle(); mem_wait = 1; repeat (2) cycle();
    mem_wait = 0; repeat (4) cycle();
    check_eq("lat3.memwait_total", {28'd0, u3_sc}, 32'd6);
    check_eq("lat1.memwait_total", {16'd0, u1_sc}, 32'd2);

    // Taken branch aborts lat3 stall at cnt=2
    set_load_use(); cycle();
    idle(); branch_taken = 1; cycle();
    branch_taken = 0; repeat (2) cycle();
    check_eq("lat3.branch_abort", {28'd0, u3_sc}, 32'd7);

    // Forwarding priority and x0 handling
    exmem_rd = 7; memwb_rd = 7; exmem_regwrite = 1; memwb_regwrite = 1; idex_rs1 = 7; idex_rs2 = 7;
    cycle();
    exmem_rd = 0; cycle();
    idle(); idex_memread = 1; idex_rd = 0; ifid_rs1 = 0; ifid_use_rs1 = 1; cycle();
    idle(); cycle();

    // Async reset mid-stall (checked before the next clock edge)
    set_load_use(); cycle();
    idle(); cycle();
    reset_n = 1'b0; cycle();
    reset_n = 1'b1; repeat (2) cycle();

    // Randomized traffic, small register space to provoke matches
    for (int i = 0; i < 600; i++) begin
      ifid_rs1 = AW'($urandom_range(0, 3)); ifid_rs2 = AW'($urandom_range(0, 3));
      ifid_use_rs1 = 1'($urandom); ifid_use_rs2 = 1'($urandom);
      idex_rs1 = AW'($urandom_range(0, 3)); idex_rs2 = AW'($urandom_range(0, 3));
      idex_rd = AW'($urandom_range(0, 3)); idex_memread = ($urandom_range(0, 2) != 0);
      exmem_rd = AW'($urandom_range(0, 3)); exmem_regwrite = 1'($urandom);
      memwb_rd = AW'($urandom_range(0, 3)); memwb_regwrite = 1'($urandom);
      mem_wait = ($urandom_range(0, 4) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      reset_n = ($urandom_range(0, 49) != 0);
      cycle();
    end
    reset_n = 1'b1;

    // Persistent load-use drives the 4-bit counter into saturation
    idle(); set_load_use(); repeat (24) cycle();
    check_eq("lat3.saturate", {28'd0, u3_sc}, 32'd15);
    idle(); cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter LOAD_LAT, default 1, load-use stall length in cycles; legal range 1..15.
REQ-003 Parameter CNT_W, default 16, stall-counter width.
REQ-004 One clock; reset is asynchronous and active-low: clk input 1 (rising edge), reset_n input 1 (active-low asynchronous reset).
REQ-005 ifid_rs1, ifid_rs2  in  REG_AW  source registers of the instruction in ID.
REQ-006 ifid_use_rs1, ifid_use_rs2  in  1  the ID instruction actually reads rs1/rs2.
REQ-007 idex_rs1, idex_rs2  in  REG_AW  source registers of the instruction in EX.
REQ-008 idex_rd, idex_memread  in  REG_AW, 1  EX destination register; EX instruction is a load.
REQ-009 exmem_rd, exmem_regwrite  in  REG_AW, 1  MEM-stage destination register and write enable.
REQ-010 memwb_rd, memwb_regwrite  in  REG_AW, 1  WB-stage destination register and write enable.
REQ-011 branch_taken  in  1  EX resolved a taken branch or jump this cycle.
REQ-012 mem_wait  in  1  data memory not ready; whole pipeline must freeze.
REQ-013 pc_write, ifid_write  out  1  PC / IF-ID register update enables.
REQ-014 idex_mux_out  out  1  1 = pass decoded control into ID-EX; 0 = insert bubble.
REQ-015 ifid_flush  out  1  clear IF-ID to NOP.
REQ-016 pipe_freeze  out  1  hold ID-EX, EX-MEM and MEM-WB.
REQ-017 forward_a, forward_b  out  2  ALU operand select: 00 = register file, 10 = EX-MEM, 01 = MEM-WB.
REQ-018 stall_cycles  out  CNT_W  saturating count of load-use stall cycles.

Function
REQ-019 Load-use hazard (LU) SHALL be: idex_memread AND idex_rd != 0 AND ((ifid_use_rs1 AND idex_rd == ifid_rs1) OR (ifid_use_rs2 AND idex_rd == ifid_rs2)).
REQ-020 Registered FSM SHALL have states RUN and LSTALL, plus a down-counter cnt of width 4.
REQ-021 Outputs SHALL be combinational from state, cnt and inputs; each cycle the highest-priority active case below applies.
REQ-022 Case 1, mem_wait=1: pc_write=0, ifid_write=0, idex_mux_out=1, ifid_flush=0, pipe_freeze=1; state, cnt and stall_cycles hold.
REQ-023 Case 2, branch_taken=1: pc_write=1, ifid_write=1, ifid_flush=1, idex_mux_out=0, pipe_freeze=0; next state RUN, cnt=0; LU is ignored and any LSTALL is aborted.
REQ-024 Case 3, state=RUN and LU=1: pc_write=0, ifid_write=0, idex_mux_out=0. If LOAD_LAT>1, next state is LSTALL with cnt=LOAD_LAT-1; otherwise next state stays RUN.
REQ-025 Case 4, state=LSTALL: outputs as in REQ-024. If cnt==1, next state is RUN with cnt=0; otherwise cnt decrements. LU is not re-evaluated in LSTALL.
REQ-026 Case 5, otherwise: pc_write=1, ifid_write=1, idex_mux_out=1, ifid_flush=0, pipe_freeze=0.
REQ-027 Total stall per load-use event SHALL be exactly LOAD_LAT cycles, excluding mem_wait cycles.
REQ-028 stall_cycles SHALL increment by 1 on each clock edge where case 3 or case 4 applies, and SHALL saturate at 2^CNT_W-1.
REQ-029 forward_a SHALL be 10 if exmem_regwrite AND exmem_rd!=0 AND exmem_rd==idex_rs1; else 01 if memwb_regwrite AND memwb_rd!=0 AND memwb_rd==idex_rs1; else 00.
REQ-030 forward_b SHALL follow the REQ-029 rule using idex_rs2.
REQ-031 EX-MEM forwarding SHALL take priority over MEM-WB when both match.
REQ-032 Forwarding SHALL be independent of mem_wait and stall state.
REQ-033 Register x0 SHALL never cause a stall or a forward.

Reset
REQ-034 While reset_n=0: state=RUN, cnt=0, stall_cycles=0; pc_write=0, ifid_write=0, idex_mux_out=0, ifid_flush=1, pipe_freeze=0, forward_a=forward_b=00.
REQ-035 Reset asserted mid-LSTALL SHALL abort the stall immediately. The first cycle after release SHALL be in RUN with normal evaluation.

Verification
REQ-036 LOAD_LAT=1; idex_memread=1, idex_rd=5, ifid_rs1=5, ifid_use_rs1=1 -> one cycle with pc_write=0, idex_mux_out=0, then RUN; stall_cycles=1.
REQ-037 LOAD_LAT=3, same load-use, no other events -> exactly 3 stall cycles (RUN, then LSTALL cnt 2, then cnt 1), then outputs return to 1; stall_cycles=3.
REQ-038 LOAD_LAT=3; mem_wait=1 for 2 cycles during LSTALL cnt=2 -> pipe_freeze=1 and cnt held at 2; stall resumes afterwards; total stall-case cycles=3.
REQ-039 branch_taken=1 while in LSTALL cnt=2 -> ifid_flush=1, idex_mux_out=0, pc_write=1 that cycle; next cycle state=RUN.
REQ-040 exmem_rd=memwb_rd=7, both regwrite=1, idex_rs1=7 -> forward_a=10. With exmem_rd=0 instead -> forward_a=01. With idex_rd=0 on a load -> no stall.
REQ-041 Assert reset_n=0 asynchronously mid-stall -> outputs take REQ-034 values without waiting for a clock edge; stall_cycles=0.
